ysyx_25010008_axil_sram: RTL and testbench
==========================================

Name: ysyx_25010008_axil_sram

Overview:
AXI4-Lite subordinate (responder) backed by an on-chip word array. It is the target-side counterpart of the core's bus initiators and arbiter. It serves single-beat reads and writes with configurable fixed latency, so the simulation SoC and arbiter can be exercised without the external io_master fabric. Read and write channels run independent FSMs.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >=2
RD_LAT, 2, cycles from AR handshake to rvalid rising; legal range 1..15
WR_LAT, 2, cycles from the cycle both AW and W are held to bvalid rising; legal range 1..15

Ports:
clock  in  1  single clock, posedge
reset  in  1  synchronous, active-high reset
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bready  in  1  write response ready
bresp  out  2  write response
bvalid  out  1  write response valid

Behaviour:
- Reset: all outputs 0 (arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata). Both FSMs return to IDLE and counters clear. Array contents are not reset. Reset mid-transaction abandons it, and no write is committed.
- Decode: hit when ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS. Index is (addr - ADDR_BASE) >> 2 and addr[1:0] is ignored. A miss gives resp 2'b10 (SLVERR); a hit gives 2'b00 (OKAY).
- Read FSM, R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1 (registered; 1 from the first cycle after reset). On arvalid&arready, latch the address, load counter=RD_LAT-1, and go to R_WAIT. With RD_LAT=1, go directly to R_RESP.
  - R_WAIT: arready=0. Decrement the counter; at 0 go to R_RESP.
  - R_RESP: rvalid=1. rdata is the array word, or 0 on a miss, sampled on entry. rresp is set on entry. rdata and rresp stay stable while rvalid&!rready.
  - On rvalid&rready: rvalid<=0 and return to R_IDLE, so arready=1 the next cycle. No back-to-back accept in the same cycle.
  - rvalid rises exactly RD_LAT cycles after the AR handshake edge.
- Write FSM, W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. The two are accepted independently, in either order or in the same cycle.
  - Once both are held, load counter=WR_LAT-1 and go to W_WAIT. awready and wready are 0 outside W_IDLE-before-capture.
  - At counter 0, commit the write (strobed bytes only; no write on a miss or when wstrb=0), then set bvalid=1 and bresp, and go to W_RESP.
  - On bvalid&bready: return to W_IDLE.
- Read/write same word, same cycle: the read sample on R_RESP entry sees the old data. A write committed on an earlier edge is visible.
- Handshake rules:
  - Outputs never depend combinationally on inputs.
  - valid, once asserted, holds until the handshake completes.
  - Initiator valids are not required to be held; the block samples only on handshake.

Decomposition:
- Shared package ysyx_25010008_axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - read states R_IDLE/R_WAIT/R_RESP
  - write states W_IDLE/W_WAIT/W_RESP
  - latency counter width 4
- One sub-module, ysyx_25010008_axil_sram_mem:
  - DEPTH_WORDS x 32 array
  - one combinational read port
  - one byte-strobed synchronous write port
  - the only place the storage is instantiated

Test Plan:
- Reset, then write 32'hDEAD_BEEF, wstrb=4'hF, to 32'h8000_0010 with AW and W in the same cycle -> bvalid exactly WR_LAT=2 cycles later, bresp=00. Reading it back -> rvalid 2 cycles after the AR handshake, rdata=32'hDEAD_BEEF, rresp=00.
- W accepted 3 cycles before AW, wstrb=4'b0101, wdata=32'h1122_3344 over 32'hDEAD_BEEF -> read returns 32'hDE22_BE44.
- Read 32'h8000_1000, just past DEPTH_WORDS=1024 -> rresp=10, rdata=0. Write to 32'h7FFF_FFFC -> bresp=10, array unchanged (verified by readback of words 0 and 1023).
- Hold rready=0 for 5 cycles with rvalid=1 -> rvalid, rdata, and rresp stable and arready=0 throughout. Raising rready -> rvalid=0 and arready=1 on the next cycle.
- Assert reset while in R_WAIT and W_WAIT (write of 32'h5555_5555 to word 4, old value 32'h0) -> all outputs 0 the next cycle. A subsequent read of word 4 returns 32'h0.
- Concurrent read and write to the same word, with the read's R_RESP entry on the same edge as the write commit -> read returns the old value. A second read returns the new value.

Source files
------------

// File: rtl/ysyx_25010008_axil_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
package ysyx_25010008_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

endpackage

// File: rtl/ysyx_25010008_axil_sram_mem.sv
// Word array with one combinational read port and one byte-strobed synchronous write port.
module ysyx_25010008_axil_sram_mem
  import ysyx_25010008_axil_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25010008_axil_sram.sv
// AXI4-Lite responder over an on-chip word array; independent read and write FSMs
// with fixed, parameterised response latency.
module ysyx_25010008_axil_sram
  import ysyx_25010008_axil_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic        bvalid
);

  localparam int unsigned     IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0]     SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  function automatic logic addr_hit(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return !off[32] && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  // Read side
  rd_state_e        rd_state;
  logic [31:0]      raddr_q;
  logic [CNT_W-1:0] rcnt;
  logic [31:0]      rd_addr_sel;
  logic [31:0]      mem_rdata;
  logic             rd_hit;
  logic             rd_last;

  // In IDLE the live address feeds the port so RD_LAT=1 can sample on the handshake edge.
  assign rd_addr_sel = (rd_state == R_IDLE) ? araddr : raddr_q;
  assign rd_hit      = addr_hit(rd_addr_sel);
  assign rd_last     = (rcnt < CNT_W'(2));

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= R_IDLE;
      raddr_q  <= '0;
      rcnt     <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            raddr_q <= araddr;
            arready <= 1'b0;
            if (RD_LAT <= 1) begin
              rd_state <= R_RESP;
              rvalid   <= 1'b1;
              rdata    <= rd_hit ? mem_rdata : '0;
              rresp    <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
              rcnt     <= RD_LOAD;
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_last) begin
            rd_state <= R_RESP;
            rvalid   <= 1'b1;
            rdata    <= rd_hit ? mem_rdata : '0;
            rresp    <= rd_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rcnt <= rcnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write side
  wr_state_e        wr_state;
  logic             aw_have;
  logic             w_have;
  logic [31:0]      awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] wcnt;
  logic             aw_hs;
  logic             w_hs;
  logic             both_now;
  logic [31:0]      wa_eff;
  logic [31:0]      wd_eff;
  logic [3:0]       ws_eff;
  logic             wr_hit;
  logic             wr_last;
  logic             commit;
  logic             mem_we;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign both_now = (aw_have || aw_hs) && (w_have || w_hs);
  assign wa_eff   = aw_have ? awaddr_q : awaddr;
  assign wd_eff   = w_have ? wdata_q : wdata;
  assign ws_eff   = w_have ? wstrb_q : wstrb;
  assign wr_hit   = addr_hit(wa_eff);
  assign wr_last  = (wcnt < CNT_W'(2));

  // Reset wins over a commit landing on the same edge, so an abandoned write never lands.
  assign commit = !reset && (((wr_state == W_IDLE) && both_now && (WR_LAT <= 1)) ||
                             ((wr_state == W_WAIT) && wr_last));
  assign mem_we = commit && wr_hit && (ws_eff != 4'h0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state <= W_IDLE;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q <= awaddr;
            aw_have  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_have  <= 1'b1;
          end
          awready <= !(aw_have || aw_hs);
          wready  <= !(w_have || w_hs);
          if (both_now) begin
            if (WR_LAT <= 1) begin
              bvalid   <= 1'b1;
              bresp    <= wr_hit ? RESP_OKAY : RESP_SLVERR;
              wr_state <= W_RESP;
            end else begin
              wcnt     <= WR_LOAD;
              wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wr_last) begin
            bvalid   <= 1'b1;
            bresp    <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            wr_state <= W_RESP;
          end else begin
            wcnt <= wcnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  ysyx_25010008_axil_sram_mem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clock(clock),
    .we   (mem_we),
    .waddr(addr_idx(wa_eff)),
    .wdata(wd_eff),
    .wstrb(ws_eff),
    .raddr(addr_idx(rd_addr_sel)),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ysyx_25010008_axil_sram.sv
// Bench for the AXI4-Lite SRAM: directed scenarios plus random traffic against a word-map model.
module tb_ysyx_25010008_axil_sram;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bready;
  logic [1:0]  bresp;
  logic        bvalid;

  always #5 clock = ~clock;

  ysyx_25010008_axil_sram #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rready (rready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bready (bready),
    .bresp  (bresp),
    .bvalid (bvalid)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Known word contents, keyed by word index; absent means never fully defined.
  logic [31:0] model [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 32'h0 : 32'h2;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int          w;
    logic [31:0] v;
    if (!in_range(a) || s == 4'h0) return;
    w = word_of(a);
    if (!model.exists(w) && s != 4'hF) return;
    v = model.exists(w) ? model[w] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    end
    model[w] = v;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (!(arready && awready && wready) && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("idle_ready", 32'({arready, awready, wready}), 32'h7);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done  = 0;
    bit hs_aw;
    bit hs_w;
    int cyc = 0;
    int lat;
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      hs_aw   = awvalid && awready;
      hs_w    = wvalid && wready;
      @(negedge clock);
      cyc++;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      if (aw_done) awaddr = $urandom();
      if (w_done) begin
        wdata = $urandom();
        wstrb = 4'($urandom());
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("w_accept", 32'({aw_done, w_done}), 32'h3);
    lat = 1;
    while (!bvalid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("b_latency", 32'(lat), 32'(WR_LAT));
    check("bresp", 32'(bresp), exp_resp(a));
    check("aw_busy", 32'({awready, wready}), 32'h0);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clock);
      check("b_hold", 32'({bvalid, bresp}), {29'h0, 1'b1, exp_resp(a)[1:0]});
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    check("b_clear", 32'({bvalid, awready, wready}), 32'h3);
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] data);
    int          cyc = 0;
    int          lat;
    logic [31:0] d0;
    logic [1:0]  r0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("ar_ready", 32'(arready), 32'h1);
    @(negedge clock);
    arvalid = 1'b0;
    araddr  = $urandom();
    lat = 1;
    while (!rvalid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("r_latency", 32'(lat), 32'(RD_LAT));
    d0 = rdata;
    r0 = rresp;
    check("rresp", 32'(r0), exp_resp(a));
    if (!in_range(a)) check("rdata_miss", d0, 32'h0);
    else if (model.exists(word_of(a))) check("rdata", d0, model[word_of(a)]);
    check("ar_busy", 32'(arready), 32'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("r_hold_valid", 32'({rvalid, arready}), 32'h2);
      check("r_hold_data", rdata, d0);
      check("r_hold_resp", 32'(rresp), 32'(r0));
    end
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    check("r_clear", 32'({rvalid, arready}), 32'h1);
    data = d0;
  endtask

  logic [31:0] rd;
  logic [31:0] old;
  logic [31:0] a;
  int          lat;

  initial begin
    reset   = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ctl", 32'({arready, awready, wready, rvalid, bvalid, rresp, bresp}), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    reset = 1'b0;

    // Full write then readback, AW and W together
    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(BASE + 32'h10, 0, rd);
    check("rb_full", rd, 32'hDEAD_BEEF);

    // W leads AW by three cycles, partial strobe
    axi_write(BASE + 32'h10, 32'h1122_3344, 4'b0101, 3, 0, 1);
    axi_read(BASE + 32'h12, 0, rd);
    check("rb_merge", rd, 32'hDE22_BE44);

    // Out-of-range accesses
    axi_write(BASE, 32'hA5A5_0000, 4'hF, 0, 1, 0);
    axi_write(BASE + 32'hFFC, 32'h0000_5A5A, 4'hF, 1, 0, 0);
    axi_read(32'h8000_1000, 0, rd);
    axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(BASE, 0, rd);
    check("miss_w0", rd, 32'hA5A5_0000);
    axi_read(BASE + 32'hFFC, 0, rd);
    check("miss_w1023", rd, 32'h0000_5A5A);

    // Backpressure on R
    axi_read(BASE + 32'h10, 5, rd);

    // Reset while both FSMs wait
    axi_write(BASE + 32'h10, 32'h0, 4'hF, 0, 0, 0);
    wait_idle();
    araddr  = BASE + 32'h10;
    arvalid = 1'b1;
    awaddr  = BASE + 32'h10;
    wdata   = 32'h5555_5555;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    check("midrst_ctl", 32'({arready, awready, wready, rvalid, bvalid, rresp, bresp}), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    reset = 1'b0;
    axi_read(BASE + 32'h10, 0, rd);
    check("midrst_word4", rd, 32'h0);

    // Same-word read and write landing on the same edge
    a   = BASE + 32'h20;
    axi_write(a, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    old = 32'h0BAD_F00D;
    wait_idle();
    araddr  = a;
    arvalid = 1'b1;
    awaddr  = a;
    wdata   = 32'hC0FF_EE00;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 1;
    while (!(rvalid && bvalid) && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("rw_latency", 32'(lat), 32'(RD_LAT));
    check("rw_old", rdata, old);
    check("rw_bresp", 32'(bresp), 32'h0);
    rready = 1'b1;
    bready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    bready = 1'b0;
    check("rw_clear", 32'({rvalid, bvalid}), 32'h0);
    model_write(a, 32'hC0FF_EE00, 4'hF);
    axi_read(a, 0, rd);
    check("rw_new", rd, 32'hC0FF_EE00);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 1) ? BASE + 4 * DEPTH + 4 * $urandom_range(0, 15)
                                 : BASE - 4 - 4 * $urandom_range(0, 15);
      end else begin
        a = BASE + 4 * ($urandom_range(0, 1) ? $urandom_range(0, 7) : 1016 + $urandom_range(0, 7))
            + $urandom_range(0, 3);
      end
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom(), 4'($urandom()), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end else begin
        axi_read(a, $urandom_range(0, 3), rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
